// File: rtl/sd_req_arbiter_pkg.sv
// sd_arb_pkg: shared states, widths and pointer wrap helper for the SD request arbiter.
package sd_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
    localparam int TO_W = 24;
    localparam int MAX_REQ = 4;
    function automatic logic [1:0] wrap_add(input logic [1:0] a, input int b, input int n);
        int s;
        s = int'(a) + b;
        return 2'(s >= n ? s - n : s);
    endfunction
endpackage

// File: rtl/sd_req_arbiter_if.sv
// sd_req_arbiter_if: requester strobes plus the shared SD block channel of the HPS bridge.
interface sd_req_arbiter_if #(parameter int NREQ = 2);
    logic [32*NREQ-1:0] req_lba;
    logic [NREQ-1:0]    req_rd, req_wr, req_busy, req_done, req_err, sd_rd, sd_wr;
    logic [31:0]        sd_lba;
    logic               sd_ack, grant_valid;
    logic [1:0]         grant_idx;
    modport master(
        output req_lba, req_rd, req_wr, sd_ack,
        input  req_busy, req_done, req_err, sd_lba, sd_rd, sd_wr, grant_valid, grant_idx
    );
    modport slave(
        input  req_lba, req_rd, req_wr, sd_ack,
        output req_busy, req_done, req_err, sd_lba, sd_rd, sd_wr, grant_valid, grant_idx
    );
endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// sd_rr_pick: first pending requester at or after the pointer, wrapping modulo NREQ.
module sd_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] i_pend,
    input  logic [1:0]      i_ptr,
    output logic            o_found,
    output logic [1:0]      o_idx
);
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        // Scan farthest distance first so the nearest pending index overwrites.
        for (int k = NREQ - 1; k >= 0; k--)
            for (int i = 0; i < NREQ; i++)
                if (i_pend[i] && wrap_add(i_ptr, k, NREQ) == 2'(i)) begin
                    o_found = 1'b1;
                    o_idx   = 2'(i);
                end
    end
endmodule

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: round-robin sharing of the HPS SD block channel among NREQ virtual disks.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int              NREQ        = 2,
    parameter logic [TO_W-1:0] ACK_TIMEOUT = 24'hFFFFFF
) (
    input logic             clk_sys,
    input logic             reset,
    sd_req_arbiter_if.slave bus
);
    state_t          r_state, w_nstate;
    logic [NREQ-1:0] r_pend_rd, r_pend_wr, r_busy, r_done, r_err, r_sd_rd, r_sd_wr;
    logic [NREQ-1:0] w_set_rd, w_set_wr, w_cap_err, w_clr, w_to_err, w_done_n;
    logic [NREQ-1:0] w_g_oh, w_n_oh, w_oh_n, w_pend_rd_n, w_pend_wr_n;
    logic [31:0]     r_lba [NREQ];
    logic [31:0]     w_lba_in [NREQ];
    logic [31:0]     r_sd_lba, w_sel_lba;
    logic [1:0]      r_ptr, r_grant, w_ptr_n, w_idx;
    logic [TO_W-1:0] r_cnt, w_cnt_n;
    logic            r_is_wr, r_gv, w_found, w_sel_wr, w_n_wr;

    sd_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_pend (r_busy),
        .i_ptr  (r_ptr),
        .o_found(w_found),
        .o_idx  (w_idx)
    );

    // A strobe on a busy requester (including its DONE cycle) is rejected; rd wins over wr.
    always_comb begin
        w_sel_lba = '0;
        w_sel_wr  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_lba_in[i]  = bus.req_lba[32*i +: 32];
            w_g_oh[i]    = r_grant == 2'(i);
            w_n_oh[i]    = w_idx == 2'(i);
            w_cap_err[i] = (bus.req_rd[i] | bus.req_wr[i]) & (r_busy[i] | (bus.req_rd[i] & bus.req_wr[i]));
            w_set_rd[i]  = bus.req_rd[i] & ~r_busy[i];
            w_set_wr[i]  = bus.req_wr[i] & ~bus.req_rd[i] & ~r_busy[i];
            if (w_n_oh[i]) begin
                w_sel_lba = r_lba[i];
                w_sel_wr  = r_pend_wr[i];
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ptr_n  = r_ptr;
        w_cnt_n  = '0;
        w_clr    = '0;
        w_to_err = '0;
        w_done_n = '0;
        case (r_state)
            IDLE:  w_nstate = w_found ? ISSUE : IDLE;
            ISSUE: begin
                if (bus.sd_ack) w_nstate = XFER;
                else if (r_cnt == ACK_TIMEOUT - 1'b1) begin
                    w_nstate = IDLE;
                    w_clr    = w_g_oh;
                    w_to_err = w_g_oh;
                    w_ptr_n  = wrap_add(r_grant, 1, NREQ);
                end else w_cnt_n = r_cnt + 1'b1;
            end
            XFER: if (!bus.sd_ack) begin
                w_nstate = DONE;
                w_done_n = w_g_oh;
            end
            DONE: begin
                w_nstate = IDLE;
                w_clr    = w_g_oh;
                w_ptr_n  = wrap_add(r_grant, 1, NREQ);
            end
            default: w_nstate = IDLE;
        endcase
        w_pend_rd_n = (r_pend_rd & ~w_clr) | w_set_rd;
        w_pend_wr_n = (r_pend_wr & ~w_clr) | w_set_wr;
        w_oh_n      = (r_state == IDLE) ? w_n_oh : w_g_oh;
        w_n_wr      = (r_state == IDLE) ? w_sel_wr : r_is_wr;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_is_wr   <= 1'b0;
            r_pend_rd <= '0;
            r_pend_wr <= '0;
            r_busy    <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_sd_rd   <= '0;
            r_sd_wr   <= '0;
            r_sd_lba  <= '0;
            r_gv      <= 1'b0;
            r_lba     <= '{default: '0};
        end else begin
            r_state   <= w_nstate;
            r_ptr     <= w_ptr_n;
            r_cnt     <= w_cnt_n;
            r_pend_rd <= w_pend_rd_n;
            r_pend_wr <= w_pend_wr_n;
            r_busy    <= w_pend_rd_n | w_pend_wr_n;
            r_done    <= w_done_n;
            r_err     <= w_cap_err | w_to_err;
            r_sd_rd   <= (w_nstate == ISSUE && !w_n_wr) ? w_oh_n : '0;
            r_sd_wr   <= (w_nstate == ISSUE && w_n_wr) ? w_oh_n : '0;
            r_gv      <= w_nstate != IDLE;
            if (r_state == IDLE && w_found) begin
                r_grant  <= w_idx;
                r_sd_lba <= w_sel_lba;
                r_is_wr  <= w_sel_wr;
            end
            for (int i = 0; i < NREQ; i++)
                if (w_set_rd[i] | w_set_wr[i]) r_lba[i] <= w_lba_in[i];
        end
    end

    assign bus.req_busy    = r_busy;
    assign bus.req_done    = r_done;
    assign bus.req_err     = r_err;
    assign bus.sd_rd       = r_sd_rd;
    assign bus.sd_wr       = r_sd_wr;
    assign bus.sd_lba      = r_sd_lba;
    assign bus.grant_valid = r_gv;
    assign bus.grant_idx   = r_grant;
endmodule
